// File: rtl/cplx_pkg.sv
// Shared opcodes, constant-register base, write-back word modes and FSM encoding
// for the complex-arithmetic instruction sequencer.
package cplx_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_CONJ = 3'b100;

  // Register indices at or above this value may name a predefined constant.
  localparam logic [3:0] CNST_BASE = 4'd9;

  localparam logic [1:0] ENDW_BOTH = 2'b00;
  localparam logic [1:0] ENDW_RE   = 2'b01;
  localparam logic [1:0] ENDW_IM   = 2'b10;
  localparam logic [1:0] ENDW_SWAP = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_RDWT,
    S_EXEC,
    S_WB
  } state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] dst;
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic       cnst_a;
    logic       cnst_b;
    logic [1:0] endw;
  } instr_t;

  function automatic logic bad_const(input logic cnst, input logic [3:0] src);
    return cnst && (src < CNST_BASE);
  endfunction

endpackage

// File: rtl/cplx_wdog_cnt.sv
// Execution watchdog: counts enabled cycles from a clear and flags the final
// cycle of a TIMEOUT-cycle window.
module cplx_wdog_cnt #(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TO_W-1:0] cnt;

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every register samples the pre-edge values of its sources.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + TO_W'(1);
    end
  end

  // Count starts at 0 on the first enabled cycle, so TIMEOUT-1 marks the last one.
  assign expired = (cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/cplx_op_sequencer.sv
// Sequences one complex instruction at a time: bank read, ALU start/done
// handshake, then write-back. Drives control pins only; all outputs registered.
module cplx_op_sequencer
  import cplx_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_op,
  input  logic [3:0] in_dst,
  input  logic [3:0] in_srcA,
  input  logic [3:0] in_srcB,
  input  logic       in_cnstA,
  input  logic       in_cnstB,
  input  logic [1:0] in_endw,
  output logic [3:0] seloutA,
  output logic [3:0] seloutB,
  output logic       cnstA,
  output logic       cnstB,
  output logic       enrregA,
  output logic       enrregB,
  output logic       regwen,
  output logic [3:0] selwreg,
  output logic [1:0] endwreg,
  output logic [2:0] alu_op,
  output logic       alu_start,
  input  logic       alu_done,
  output logic       done,
  output logic       err,
  output logic       busy
);

  state_t state, state_next;
  instr_t instr_q, instr_next;
  logic   done_next, err_next, start_next;
  logic   busy_next, in_exec, wdog_expired;

  assign in_exec   = (state == S_EXEC);
  assign busy_next = (state_next != S_IDLE);

  cplx_wdog_cnt #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_wdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (!in_exec),
    .enable  (in_exec),
    .expired (wdog_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      instr_q <= '0;
    end else begin
      state   <= state_next;
      instr_q <= instr_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    instr_next = instr_q;
    done_next  = 1'b0;
    err_next   = 1'b0;
    start_next = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          instr_next = '{op: in_op, dst: in_dst, src_a: in_srcA, src_b: in_srcB,
                         cnst_a: in_cnstA, cnst_b: in_cnstB, endw: in_endw};
          if (bad_const(in_cnstA, in_srcA) || bad_const(in_cnstB, in_srcB)) begin
            err_next = 1'b1;
          end else if (in_op == OP_NOP) begin
            done_next = 1'b1;
          end else begin
            state_next = S_READ;
          end
        end
      end
      S_READ: state_next = S_RDWT;
      S_RDWT: begin
        state_next = S_EXEC;
        start_next = 1'b1;
      end
      S_EXEC: begin
        // A late alu_done on the final watchdog cycle still completes the instruction.
        if (alu_done) begin
          state_next = S_WB;
        end else if (wdog_expired) begin
          state_next = S_IDLE;
          err_next   = 1'b1;
        end
      end
      S_WB: begin
        state_next = S_IDLE;
        done_next  = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each pin changes with the state itself.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      seloutA   <= '0;
      seloutB   <= '0;
      cnstA     <= 1'b0;
      cnstB     <= 1'b0;
      enrregA   <= 1'b0;
      enrregB   <= 1'b0;
      regwen    <= 1'b0;
      selwreg   <= '0;
      endwreg   <= '0;
      alu_op    <= OP_NOP;
      alu_start <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      in_ready  <= !busy_next;
      busy      <= busy_next;
      seloutA   <= busy_next ? instr_next.src_a  : '0;
      seloutB   <= busy_next ? instr_next.src_b  : '0;
      cnstA     <= busy_next && instr_next.cnst_a;
      cnstB     <= busy_next && instr_next.cnst_b;
      enrregA   <= (state_next == S_READ);
      enrregB   <= (state_next == S_READ);
      regwen    <= (state_next == S_WB);
      selwreg   <= busy_next ? instr_next.dst  : '0;
      endwreg   <= busy_next ? instr_next.endw : '0;
      alu_op    <= (state_next == S_EXEC || state_next == S_WB) ? instr_next.op : OP_NOP;
      alu_start <= start_next;
      done      <= done_next;
      err       <= err_next;
    end
  end

endmodule

// File: tb/tb_cplx_op_sequencer.sv
// Scoreboard bench for cplx_op_sequencer: a behavioural ALU answers alu_start,
// and every retirement is checked against the expectation queued at issue.
module tb_cplx_op_sequencer;
  import cplx_pkg::*;

  localparam int TIMEOUT = 64;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_op = '0;
  logic [3:0] in_dst = '0, in_srcA = '0, in_srcB = '0;
  logic       in_cnstA = 1'b0, in_cnstB = 1'b0;
  logic [1:0] in_endw = '0;
  logic [3:0] seloutA, seloutB, selwreg;
  logic       cnstA, cnstB, enrregA, enrregB, regwen;
  logic [1:0] endwreg;
  logic [2:0] alu_op;
  logic       alu_start, done, err, busy;
  logic       alu_done = 1'b0;

  cplx_op_sequencer #(.TIMEOUT(TIMEOUT), .TO_W(7)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_dst    (in_dst),
    .in_srcA   (in_srcA),
    .in_srcB   (in_srcB),
    .in_cnstA  (in_cnstA),
    .in_cnstB  (in_cnstB),
    .in_endw   (in_endw),
    .seloutA   (seloutA),
    .seloutB   (seloutB),
    .cnstA     (cnstA),
    .cnstB     (cnstB),
    .enrregA   (enrregA),
    .enrregB   (enrregB),
    .regwen    (regwen),
    .selwreg   (selwreg),
    .endwreg   (endwreg),
    .alu_op    (alu_op),
    .alu_start (alu_start),
    .alu_done  (alu_done),
    .done      (done),
    .err       (err),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit         is_err;
    bit         wb;
    logic [3:0] dst;
    logic [1:0] endw;
    int         acc;
    int         lat;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural ALU: alu_done is high in the k-th cycle counting the alu_start cycle as 1.
  int alu_k = 0;
  int alu_wait = 0;
  always @(negedge clock) begin
    alu_done = 1'b0;
    if (alu_start) alu_wait = alu_k;
    if (alu_wait > 0) begin
      alu_wait--;
      if (alu_wait == 0) alu_done = 1'b1;
    end
  end

  // Retirement monitor: pops the oldest expectation on every done/err pulse.
  bit         wb_seen = 1'b0;
  logic [3:0] wb_dst;
  logic [1:0] wb_endw;
  exp_t       mon_e;
  always @(negedge clock) begin
    if (reset) begin
      wb_seen = 1'b0;
    end else begin
      if (regwen || done || err) begin
        vectors++;
        if ((regwen && (enrregA || enrregB)) || (done && err)) begin
          miscompares++;
          $display("FAIL strobe_exclusive: regwen=%b enrreg=%b%b done=%b err=%b, required exclusive",
                   regwen, enrregA, enrregB, done, err);
        end
      end
      if (regwen) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL stray_regwen: regwen=1 at cycle %0d, required 0 (nothing outstanding)", cyc);
        end
        wb_seen = 1'b1;
        wb_dst  = selwreg;
        wb_endw = endwreg;
      end
      if (done || err) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL stray_retire: done=%b err=%b at cycle %0d, required none", done, err, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (err !== mon_e.is_err || (cyc - mon_e.acc) != mon_e.lat || wb_seen !== mon_e.wb ||
              (mon_e.wb && (wb_dst !== mon_e.dst || wb_endw !== mon_e.endw))) begin
            miscompares++;
            $display("FAIL retire: got err=%b lat=%0d wb=%b dst=%0d endw=%b, required err=%b lat=%0d wb=%b dst=%0d endw=%b",
                     err, cyc - mon_e.acc, wb_seen, wb_dst, wb_endw,
                     mon_e.is_err, mon_e.lat, mon_e.wb, mon_e.dst, mon_e.endw);
          end
        end
        wb_seen = 1'b0;
      end
    end
  end

  // Drives one instruction, queues its expected outcome, returns the first cycle after acceptance.
  task automatic send(input logic [2:0] op, input logic [3:0] dst, input logic [3:0] a,
                      input logic [3:0] b, input logic ca, input logic cb,
                      input logic [1:0] endw, input int k, input bit hold, output int acc);
    exp_t e;
    bit   illegal, nop;
    int   n = 0;
    @(negedge clock);
    in_op = op; in_dst = dst; in_srcA = a; in_srcB = b;
    in_cnstA = ca; in_cnstB = cb; in_endw = endw; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: in_ready=0 for %0d cycles, required 1", n);
      in_valid = 1'b0;
      acc = -1;
      return;
    end
    illegal  = (ca && a < 4'd9) || (cb && b < 4'd9);
    nop      = (op == OP_NOP);
    e.wb     = !illegal && !nop && k >= 1 && k <= TIMEOUT;
    e.is_err = illegal || (!nop && !e.wb);
    e.lat    = (illegal || nop) ? 0 : (e.wb ? 3 + k : 2 + TIMEOUT);
    e.dst    = dst;
    e.endw   = endw;
    e.acc    = cyc + 1;
    exp_q.push_back(e);
    alu_k = k;
    @(negedge clock);
    if (!hold) in_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d pending after %0d cycles, required 0", exp_q.size(), budget);
      exp_q.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    vectors += 2;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
    end
    if ({busy, enrregA, enrregB, regwen, alu_start, done, err, cnstA, cnstB,
         seloutA, seloutB, selwreg, endwreg, alu_op} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b enrreg=%b%b regwen=%b start=%b done=%b err=%b sel=%0d/%0d, required all 0",
               busy, enrregA, enrregB, regwen, alu_start, done, err, seloutA, seloutB);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_add_timing();
    int acc, t_rd = -1, t_st = -1, t_wb = -1, t_dn = -1;
    logic [3:0] sa = '0, sb = '0, wsel = '0;
    logic [2:0] op_st = '0;
    send(OP_ADD, 4'd7, 4'd2, 4'd5, 1'b0, 1'b0, ENDW_BOTH, 3, 1'b0, acc);
    for (int i = 0; i < 12; i++) begin
      if (enrregA && enrregB && t_rd < 0) begin t_rd = cyc; sa = seloutA; sb = seloutB; end
      if (alu_start && t_st < 0) begin t_st = cyc; op_st = alu_op; end
      if (regwen && t_wb < 0) begin t_wb = cyc; wsel = selwreg; end
      if (done && t_dn < 0) t_dn = cyc;
      @(negedge clock);
    end
    vectors += 6;
    if (t_rd - acc != 0) begin miscompares++; $display("FAIL add_enrreg_time: offset %0d, required 0", t_rd - acc); end
    if (t_st - acc != 2) begin miscompares++; $display("FAIL add_start_time: offset %0d, required 2", t_st - acc); end
    if (t_wb - acc != 5) begin miscompares++; $display("FAIL add_regwen_time: offset %0d, required 5", t_wb - acc); end
    if (t_dn - acc != 6) begin miscompares++; $display("FAIL add_done_time: offset %0d, required 6", t_dn - acc); end
    if (sa !== 4'd2 || sb !== 4'd5 || wsel !== 4'd7) begin
      miscompares++;
      $display("FAIL add_selects: A=%0d B=%0d W=%0d, required 2 5 7", sa, sb, wsel);
    end
    if (op_st !== OP_ADD) begin miscompares++; $display("FAIL add_alu_op: %0d, required %0d", op_st, OP_ADD); end
    drain(20);
  endtask

  task automatic test_illegal();
    int acc, t_err = -1, strobes = 0;
    send(OP_ADD, 4'd3, 4'd4, 4'd6, 1'b1, 1'b0, ENDW_BOTH, 3, 1'b0, acc);
    for (int i = 0; i < 6; i++) begin
      if (err && t_err < 0) t_err = cyc;
      if (enrregA || enrregB || regwen || alu_start) strobes++;
      @(negedge clock);
    end
    vectors += 2;
    if (t_err - acc != 0) begin miscompares++; $display("FAIL illegal_err_time: offset %0d, required 0", t_err - acc); end
    if (strobes != 0) begin miscompares++; $display("FAIL illegal_strobes: %0d strobe cycles, required 0", strobes); end
    drain(10);
    send(OP_SUB, 4'd1, 4'd0, 4'd8, 1'b0, 1'b1, ENDW_RE, 2, 1'b0, acc);
    drain(10);
    send(OP_SUB, 4'd2, 4'd9, 4'd1, 1'b1, 1'b0, ENDW_IM, 2, 1'b0, acc);
    drain(20);
  endtask

  task automatic test_const_b();
    int acc;
    logic cb_rd = 1'b0, ca_rd = 1'b1;
    logic [3:0] sb_rd = '0;
    logic [1:0] ew_wb = '0;
    send(OP_MUL, 4'd12, 4'd3, 4'd15, 1'b0, 1'b1, ENDW_SWAP, 1, 1'b0, acc);
    for (int i = 0; i < 8; i++) begin
      if (enrregB) begin cb_rd = cnstB; ca_rd = cnstA; sb_rd = seloutB; end
      if (regwen) ew_wb = endwreg;
      @(negedge clock);
    end
    vectors += 2;
    if (cb_rd !== 1'b1 || ca_rd !== 1'b0 || sb_rd !== 4'd15) begin
      miscompares++;
      $display("FAIL constb_read: cnstB=%b cnstA=%b seloutB=%0d, required 1 0 15", cb_rd, ca_rd, sb_rd);
    end
    if (ew_wb !== ENDW_SWAP) begin miscompares++; $display("FAIL constb_endw: %b, required 11", ew_wb); end
    drain(20);
  endtask

  task automatic test_nop();
    int acc, t_dn = -1, busy_cnt = 0;
    send(OP_NOP, 4'd4, 4'd1, 4'd1, 1'b0, 1'b0, ENDW_RE, 0, 1'b0, acc);
    for (int i = 0; i < 4; i++) begin
      if (done && t_dn < 0) t_dn = cyc;
      if (busy) busy_cnt++;
      @(negedge clock);
    end
    vectors += 2;
    if (t_dn - acc != 0) begin miscompares++; $display("FAIL nop_done_time: offset %0d, required 0", t_dn - acc); end
    if (busy_cnt != 0) begin miscompares++; $display("FAIL nop_busy: %0d busy cycles, required 0", busy_cnt); end
    drain(10);
  endtask

  task automatic test_timeout();
    int acc, t_st = -1, t_err = -1, wb_cnt = 0;
    send(OP_SUB, 4'd9, 4'd1, 4'd2, 1'b0, 1'b0, ENDW_IM, 0, 1'b0, acc);
    for (int i = 0; i < 80 && t_err < 0; i++) begin
      if (alu_start && t_st < 0) t_st = cyc;
      if (err) t_err = cyc;
      if (regwen) wb_cnt++;
      @(negedge clock);
    end
    vectors += 2;
    if (t_st < 0 || t_err - t_st != TIMEOUT) begin
      miscompares++;
      $display("FAIL timeout_err_time: start=%0d err=%0d, required err %0d after start", t_st, t_err, TIMEOUT);
    end
    if (wb_cnt != 0) begin miscompares++; $display("FAIL timeout_regwen: %0d, required 0", wb_cnt); end
    drain(10);
    send(OP_ADD, 4'd6, 4'd1, 4'd2, 1'b0, 1'b0, ENDW_BOTH, TIMEOUT, 1'b0, acc);
    drain(100);
  endtask

  task automatic test_reset_exec();
    int acc, n = 0, late = 0;
    send(OP_ADD, 4'd5, 4'd1, 4'd2, 1'b0, 1'b0, ENDW_BOTH, 6, 1'b0, acc);
    while (!alu_start && n < 10) begin @(negedge clock); n++; end
    @(negedge clock);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    vectors += 2;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstexec_ready: in_ready=%b, required 1", in_ready); end
    if ({busy, enrregA, enrregB, regwen, alu_start, done, err} !== 7'b0) begin
      miscompares++;
      $display("FAIL rstexec_strobes: busy=%b enrreg=%b%b regwen=%b start=%b done=%b err=%b, required 0",
               busy, enrregA, enrregB, regwen, alu_start, done, err);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (done || err || regwen || busy) late++;
    end
    vectors++;
    if (late != 0) begin miscompares++; $display("FAIL rstexec_late: %0d active cycles, required 0", late); end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2;
    send(OP_ADD, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, ENDW_BOTH, 2, 1'b1, acc1);
    send(OP_CONJ, 4'd2, 4'd4, 4'd10, 1'b0, 1'b1, ENDW_RE, 1, 1'b0, acc2);
    vectors += 2;
    if (acc2 - acc1 != 6) begin miscompares++; $display("FAIL b2b_accept: gap %0d, required 6", acc2 - acc1); end
    if (enrregA !== 1'b1 || seloutA !== 4'd4) begin
      miscompares++;
      $display("FAIL b2b_read: enrregA=%b seloutA=%0d, required 1 4", enrregA, seloutA);
    end
    drain(20);
  endtask

  task automatic test_random();
    int acc;
    for (int i = 0; i < 8; i++) begin
      send(3'($urandom_range(0, 4)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           2'($urandom_range(0, 3)), $urandom_range(1, 5), 1'b0, acc);
      drain(20);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish, required completion");
    $fatal(1, "bench hung");
  end

  initial begin
    test_reset();
    test_add_timing();
    test_illegal();
    test_const_b();
    test_nop();
    test_timeout();
    test_reset_exec();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
